// File: rtl/desloc_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : desloc_seq
// Description : Command sequencer for a universal shift register. Accepts
//               load / shift-left N / shift-right N / nop commands over a
//               valid/ready handshake and drives op, serial_in and
//               parallel_in cycle by cycle. Completion is a one-cycle done
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module desloc_seq #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [1:0]       op,
   output logic             serial_in,
   output logic [WIDTH-1:0] parallel_in,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0]       C_OP_HOLD  = 2'b00;
   localparam logic [1:0]       C_OP_LEFT  = 2'b01;
   localparam logic [1:0]       C_OP_RIGHT = 2'b10;
   localparam logic [1:0]       C_OP_LOAD  = 2'b11;
   localparam logic [CNT_W-1:0] C_MAX_CNT  = CNT_W'(WIDTH);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_data,  w_data_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic [CNT_W-1:0] r_k,     w_k_nxt;
   logic [1:0]       r_op,    w_op_nxt;
   logic             r_sin,   w_sin_nxt;
   logic [WIDTH-1:0] r_pin,   w_pin_nxt;
   logic             r_busy,  w_busy_nxt;
   logic             r_done,  w_done_nxt;

   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_clamp;
   logic [CNT_W-1:0] w_k_inc;

   // Serial bit for shift index k: MSB-first for left, LSB-first for right,
   // so a full-width shift rebuilds the word unchanged in the register.
   function automatic logic f_bit(input logic [WIDTH-1:0] d,
                                  input logic             left,
                                  input logic [CNT_W-1:0] k);
      logic [WIDTH-1:0] t;
      if (left) begin
         t     = d << k;
         f_bit = t[WIDTH-1];
      end else begin
         t     = d >> k;
         f_bit = t[0];
      end
   endfunction

   assign cmd_ready   = (r_state == S_IDLE) && !reset;
   assign w_accept    = cmd_valid && cmd_ready;
   assign w_cnt_clamp = (cmd_count > C_MAX_CNT) ? C_MAX_CNT : cmd_count;
   assign w_k_inc     = r_k + CNT_W'(1);

   assign op          = r_op;
   assign serial_in   = r_sin;
   assign parallel_in = r_pin;
   assign busy        = r_busy;
   assign done        = r_done;

   // Next-state and next-output decode; outputs are computed one cycle ahead
   // so that they are registered yet line up with the state they belong to.
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      w_k_nxt     = r_k;
      w_op_nxt    = C_OP_HOLD;
      w_sin_nxt   = 1'b0;
      w_pin_nxt   = r_pin;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_data_nxt = cmd_data;
               w_cnt_nxt  = w_cnt_clamp;
               w_k_nxt    = '0;
               if (cmd_op == C_OP_LOAD) begin
                  w_state_nxt = S_LOAD;
                  w_op_nxt    = C_OP_LOAD;
                  w_pin_nxt   = cmd_data;
               end else if (((cmd_op == C_OP_LEFT) || (cmd_op == C_OP_RIGHT)) &&
                            (w_cnt_clamp != '0)) begin
                  w_state_nxt = S_SHIFT;
                  w_op_nxt    = cmd_op;
                  w_sin_nxt   = f_bit(cmd_data, cmd_op == C_OP_LEFT, '0);
               end else begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         S_LOAD: begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
         end
         S_SHIFT: begin
            if (w_k_inc == r_cnt) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_k_nxt   = w_k_inc;
               w_op_nxt  = r_op;
               w_sin_nxt = f_bit(r_data, r_op == C_OP_LEFT, w_k_inc);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers; reset drops any command in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_k     <= '0;
         r_op    <= C_OP_HOLD;
         r_sin   <= 1'b0;
         r_pin   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_cnt   <= w_cnt_nxt;
         r_k     <= w_k_nxt;
         r_op    <= w_op_nxt;
         r_sin   <= w_sin_nxt;
         r_pin   <= w_pin_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

endmodule
`default_nettype wire

// File: doc/desloc_seq.md
Name: desloc_seq

Overview:
- Upstream command sequencer for the 4-bit universal shift register (`reg_desloc`).
- Accepts one command at a time over a valid/ready handshake: load, shift-left N, shift-right N, or nop.
- Drives the register's `op`, `serial_in` and `parallel_in` cycle by cycle, so a stored word can be rebuilt serially or loaded in parallel.
- Reports completion with a one-cycle `done` pulse.

Parameters:
- WIDTH, 4, data width; must match the shift register width.
- CNT_W, 3, width of `cmd_count`; must be at least clog2(WIDTH+1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  command code: 00 nop, 01 shift left, 10 shift right, 11 parallel load.
- cmd_count  input  CNT_W  number of shift cycles (shift commands only).
- cmd_data  input  WIDTH  word to load, or serial bit source for shifts.
- op  output  2  op code to the shift register: 00 hold, 01 left, 10 right, 11 load.
- serial_in  output  1  serial bit to the shift register.
- parallel_in  output  WIDTH  parallel word to the shift register.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (checked at the clock edge, overrides everything, also mid-command):
  - state returns to IDLE.
  - op=00, serial_in=0, parallel_in=0, busy=0, done=0.
  - Any command in progress is dropped.
  - cmd_ready=0 while reset is high.
- Output timing:
  - `op`, `serial_in`, `parallel_in`, `busy` and `done` are all registered.
  - `cmd_ready` = (state==IDLE) && !reset.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_op, cmd_data and the count are captured at that edge.
  - Inputs are ignored while cmd_ready=0.
- Count rule: the captured count is min(cmd_count, WIDTH).
- State IDLE:
  - op=00, busy=0.
  - On accept:
    - cmd_op 11 -> LOAD.
    - cmd_op 01/10 with count>0 -> SHIFT.
    - cmd_op 00, or count==0 -> DONE.
  - busy=1 from the cycle after accept.
- State LOAD:
  - Exactly one cycle: op=11, parallel_in=data.
  - Then -> DONE.
- State SHIFT:
  - Lasts exactly `count` cycles with op=01 or 10; an internal index k runs 0..count-1.
  - Left shift: serial_in = data[WIDTH-1-k] (MSB first).
  - Right shift: serial_in = data[k] (LSB first).
  - With count==WIDTH, the register holds `data` after the final shift edge.
  - After the last cycle -> DONE.
- State DONE:
  - One cycle: op=00, done=1, busy=1.
  - Then -> IDLE with busy=0; a new command is acceptable on the next edge.
- Latency (accept edge to done high): load 2 cycles, shift count+1 cycles, nop 1 cycle.
- Back-to-back: minimum spacing between accepts is latency+1 cycles. No command queueing.
- Hold values:
  - parallel_in keeps its last driven value outside LOAD.
  - serial_in is 0 whenever op is not 01/10.
  - op is never 01/10/11 outside SHIFT/LOAD.
- Undefined-input guard: X on cmd_op while not accepted has no effect.

Test Plan:
- Reset, then load: hold reset 2 cycles -> op=00, busy=0, done=0, cmd_ready=0 during reset, 1 after. Then load cmd_data=4'b1010 -> op=11 and parallel_in=1010 for exactly 1 cycle; done pulses on the next cycle; register reads 1010.
- Shift left full word: cmd_op=01, count=4, data=4'b1101 -> 4 cycles of op=01 with serial_in sequence 1,1,0,1; register ends at 1101; done at accept+5.
- Shift right full word: cmd_op=10, count=4, data=4'b0011 -> serial_in sequence 1,1,0,0; register ends at 0011; done at accept+5.
- Boundary counts:
  - count=0 shift -> no op≠00 cycle; done at accept+1.
  - count=7 -> clamped to 4 shift cycles.
  - cmd_op=00 -> done at accept+1, op stays 00.
- Handshake stress: hold cmd_valid high with changing cmd_data during SHIFT -> no new accept until IDLE; the second command starts the cycle after IDLE is re-entered.
- Reset mid-shift after 2 of 4 shifts -> op=00, busy=0, done never pulses; cmd_ready=1 the cycle after reset drops; a fresh load of 1111 completes normally.
